// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants and types for the capture/display block.
//   SEG_HEX  - active-low gfedcba patterns for hex digits 0..F
//   SEG_OFF  - all segments off
//   disp_state_t - display FSM states (IDLE, BLINK)
package seg7_pkg;

    localparam int unsigned SEG_W = 7;

    localparam logic [SEG_W-1:0] SEG_OFF = 7'h7F;

    localparam logic [SEG_W-1:0] SEG_HEX [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef enum logic {
        IDLE  = 1'b0,
        BLINK = 1'b1
    } disp_state_t;

    // Width of a counter holding 0..v-1, never less than one bit.
    function automatic int unsigned cnt_w(input int unsigned v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/seg7_encode.sv
// seg7_encode: nibble to active-low 7-segment pattern.
//   nibble    - hex value 0..F
//   blank     - force all segments off
//   pattern_c - gfedcba, active low (combinational)
module seg7_encode
    import seg7_pkg::*;
(
    input  logic [3:0]       nibble,
    input  logic             blank,
    output logic [SEG_W-1:0] pattern_c
);

    assign pattern_c = blank ? SEG_OFF : SEG_HEX[nibble];

endmodule

// File: rtl/seg7_capture_display.sv
// seg7_capture_display: latches a DATA_W-bit word on a strobe and shows it
// in hex on NUM_DIGITS active-low 7-segment digits, with paging for wide
// words, capture hold/clear and a blink burst after each new capture.
// Optional macro SEG7_LZ_BLANK_EN enables leading-zero blanking per page.
//   sys_clk   - clock
//   rst       - asynchronous active-high reset
//   cap_valid - single-cycle capture strobe, cap_data the value to latch
//   hold      - ignore cap_valid while high
//   clear     - synchronous clear of capture, page and blink state
//   page_adv  - single-cycle pulse advancing the displayed page
//   seg_n     - digit i at [7i+6:7i], gfedcba, active low (registered)
//   page_idx  - current page (registered)
//   new_flag  - high while the blink burst runs (registered)
module seg7_capture_display
    import seg7_pkg::*;
#(
    parameter  int unsigned NUM_DIGITS   = 6,
    parameter  int unsigned DATA_W       = 32,
    parameter  int unsigned BLINK_HALF   = 12_500_000,
    parameter  int unsigned BLINK_HALVES = 4,
    localparam int unsigned NUM_NIB      = DATA_W / 4,
    localparam int unsigned NUM_PAGES    = (NUM_NIB + NUM_DIGITS - 1) / NUM_DIGITS,
    localparam int unsigned PW           = cnt_w(NUM_PAGES)
)(
    input  logic                        sys_clk,
    input  logic                        rst,
    input  logic                        cap_valid,
    input  logic [DATA_W-1:0]           cap_data,
    input  logic                        hold,
    input  logic                        clear,
    input  logic                        page_adv,
    output logic [SEG_W*NUM_DIGITS-1:0] seg_n,
    output logic [PW-1:0]               page_idx,
    output logic                        new_flag
);

    localparam int unsigned HCW   = cnt_w(BLINK_HALF);
    localparam int unsigned HVW   = $clog2(BLINK_HALVES + 1);
    localparam int unsigned PAD_W = 4 * NUM_PAGES * NUM_DIGITS;

    logic [DATA_W-1:0]           cap_reg;
    disp_state_t                 state;
    logic [HCW-1:0]              half_cnt;
    logic [HVW-1:0]              halves;
    logic                        capture_c;
    logic                        blink_off_c;
    logic [PAD_W-1:0]            padded_c;
    logic [SEG_W*NUM_DIGITS-1:0] seg_c;

    assign capture_c   = cap_valid & ~hold & ~clear;
    assign blink_off_c = (state == BLINK) & halves[0];
    // Zero-extend so every page slot has a nibble to select.
    assign padded_c    = PAD_W'(cap_reg);

    // Capture register and page pointer; clear beats capture beats page_adv.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            cap_reg  <= '0;
            page_idx <= '0;
        end else if (clear) begin
            cap_reg  <= '0;
            page_idx <= '0;
        end else if (capture_c) begin
            cap_reg  <= cap_data;
            page_idx <= '0;
        end else if (page_adv && (NUM_PAGES > 1)) begin
            if (page_idx == PW'(NUM_PAGES - 1)) begin
                page_idx <= '0;
            end else begin
                page_idx <= page_idx + PW'(1);
            end
        end
    end

    // Blink FSM: a burst of BLINK_HALVES half-periods, restarted by capture.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            half_cnt <= '0;
            halves   <= '0;
            new_flag <= 1'b0;
        end else if (clear) begin
            state    <= IDLE;
            half_cnt <= '0;
            halves   <= '0;
            new_flag <= 1'b0;
        end else if (capture_c) begin
            state    <= BLINK;
            half_cnt <= '0;
            halves   <= '0;
            new_flag <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    new_flag <= 1'b0;
                end
                BLINK: begin
                    if (half_cnt == HCW'(BLINK_HALF - 1)) begin
                        half_cnt <= '0;
                        // Last half-period ends the burst; counters return to 0.
                        if (halves == HVW'(BLINK_HALVES - 1)) begin
                            state    <= IDLE;
                            halves   <= '0;
                            new_flag <= 1'b0;
                        end else begin
                            halves <= halves + HVW'(1);
                        end
                    end else begin
                        half_cnt <= half_cnt + HCW'(1);
                    end
                end
                default: begin
                    state    <= IDLE;
                    new_flag <= 1'b0;
                end
            endcase
        end
    end

`ifdef SEG7_LZ_BLANK_EN
    // lz_chain[g] is high when digit g and every higher digit on the page are zero.
    logic [NUM_DIGITS:0] lz_chain;
    assign lz_chain[NUM_DIGITS] = 1'b1;
`endif

    // Per-digit nibble selection and encoding.
    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        logic [31:0] nib_idx;
        logic        in_range;
        logic [3:0]  nib;
        logic        lz_blank;

        assign nib_idx  = 32'(page_idx) * NUM_DIGITS + 32'(g);
        assign in_range = nib_idx < NUM_NIB;
        // Out-of-range slots read as zero, which also feeds the leading-zero rule.
        assign nib      = in_range ? 4'(padded_c >> (nib_idx * 4)) : 4'h0;

`ifdef SEG7_LZ_BLANK_EN
        assign lz_chain[g] = lz_chain[g+1] & (nib == 4'h0);
        assign lz_blank    = (g != 0) & lz_chain[g];
`else
        assign lz_blank    = 1'b0;
`endif

        seg7_encode u_encode (
            .nibble    (nib),
            .blank     (blink_off_c | ~in_range | lz_blank),
            .pattern_c (seg_c[SEG_W*g +: SEG_W])
        );
    end

    // Output segment register.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            seg_n <= '1;
        end else begin
            seg_n <= seg_c;
        end
    end

endmodule

// File: tb/tb_seg7_capture_display.sv
// tb_seg7_capture_display: directed self-checking bench for
// seg7_capture_display with a short blink (BLINK_HALF=4, BLINK_HALVES=4).
// Expected segment words are pushed to a scoreboard queue as each cycle's
// stimulus is driven and popped when the registered output appears.
module tb_seg7_capture_display;

    localparam int unsigned ND  = 6;
    localparam int unsigned DW  = 32;
    localparam int unsigned BH  = 4;
    localparam int unsigned BHV = 4;
    localparam int unsigned NP  = 2;
    localparam int unsigned NN  = DW / 4;

    localparam logic [41:0] ALL_OFF = {6{7'h7F}};
    localparam logic [41:0] ALL_40  = {6{7'h40}};
    localparam logic [41:0] ADBEEF  = {7'h08, 7'h21, 7'h03, 7'h06, 7'h06, 7'h0E};
    localparam logic [41:0] PAGE1   = {{4{7'h7F}}, 7'h21, 7'h06};
`ifdef SEG7_LZ_BLANK_EN
    localparam logic [41:0] VAL_1   = {{5{7'h7F}}, 7'h79};
    localparam logic [41:0] VAL_A5  = {{4{7'h7F}}, 7'h08, 7'h12};
    localparam logic [41:0] VAL_0   = {{5{7'h7F}}, 7'h40};
`else
    localparam logic [41:0] VAL_1   = {{5{7'h40}}, 7'h79};
    localparam logic [41:0] VAL_A5  = {{4{7'h40}}, 7'h08, 7'h12};
    localparam logic [41:0] VAL_0   = {6{7'h40}};
`endif

    logic        sys_clk   = 1'b0;
    logic        rst       = 1'b1;
    logic        cap_valid = 1'b0;
    logic [31:0] cap_data  = '0;
    logic        hold      = 1'b0;
    logic        clear     = 1'b0;
    logic        page_adv  = 1'b0;
    logic [41:0] seg_n;
    logic [0:0]  page_idx;
    logic        new_flag;

    int n_pass  = 0;
    int n_total = 0;

    logic [41:0] sb_q[$];

    // Reference model state: value, page, burst active and cycle within burst.
    logic [31:0] m_val  = '0;
    int          m_page = 0;
    bit          m_on   = 1'b0;
    int          m_cnt  = 0;

    always #5 sys_clk = ~sys_clk;

    seg7_capture_display #(
        .NUM_DIGITS   (ND),
        .DATA_W       (DW),
        .BLINK_HALF   (BH),
        .BLINK_HALVES (BHV)
    ) dut (
        .sys_clk   (sys_clk),
        .rst       (rst),
        .cap_valid (cap_valid),
        .cap_data  (cap_data),
        .hold      (hold),
        .clear     (clear),
        .page_adv  (page_adv),
        .seg_n     (seg_n),
        .page_idx  (page_idx),
        .new_flag  (new_flag)
    );

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
            4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
            4'h8: return 7'h00; 4'h9: return 7'h18; 4'hA: return 7'h08; 4'hB: return 7'h03;
            4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h06; default: return 7'h0E;
        endcase
    endfunction

    function automatic logic [41:0] exp_seg(input logic [31:0] v, input int pg, input bit blk);
        logic [41:0] r;
        bit          lz;
        r  = '0;
        lz = 1'b1;
        for (int i = ND - 1; i >= 0; i--) begin
            int         idx;
            logic [3:0] n;
            bit         lzb;
            idx = pg * ND + i;
            n   = (idx < NN) ? v[idx*4 +: 4] : 4'h0;
            lz  = lz && (n == 4'h0);
`ifdef SEG7_LZ_BLANK_EN
            lzb = (i > 0) && lz;
`else
            lzb = 1'b0;
`endif
            r[i*7 +: 7] = (blk || idx >= NN || lzb) ? 7'h7F : hex7(n);
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        assert (got === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive inputs, predict, clock, check outputs.
    task automatic step(input bit cv, input logic [31:0] d, input bit h, input bit clr,
                        input bit pa, input string tag);
        logic [41:0] exp_s;
        cap_valid = cv;
        cap_data  = d;
        hold      = h;
        clear     = clr;
        page_adv  = pa;
        // seg_n after this edge reflects the registers as they are now.
        sb_q.push_back(exp_seg(m_val, m_page, m_on && (((m_cnt / BH) % 2) == 1)));
        if (clr) begin
            m_val = '0; m_page = 0; m_on = 1'b0; m_cnt = 0;
        end else if (cv && !h) begin
            m_val = d; m_page = 0; m_on = 1'b1; m_cnt = 0;
        end else begin
            if (pa) m_page = (m_page + 1) % NP;
            if (m_on) begin
                m_cnt++;
                if (m_cnt == BH * BHV) begin
                    m_on  = 1'b0;
                    m_cnt = 0;
                end
            end
        end
        @(posedge sys_clk);
        #1;
        cap_valid = 1'b0;
        hold      = 1'b0;
        clear     = 1'b0;
        page_adv  = 1'b0;
        exp_s = sb_q.pop_front();
        chk({tag, " seg_n"},    64'(seg_n),    64'(exp_s));
        chk({tag, " new_flag"}, 64'(new_flag), 64'(m_on));
        chk({tag, " page_idx"}, 64'(page_idx), 64'(m_page));
    endtask

    task automatic idle(input int n, input string tag);
        for (int k = 0; k < n; k++) step(1'b0, '0, 1'b0, 1'b0, 1'b0, tag);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

    initial begin
        int hi;

        // Reset held: everything off.
        repeat (2) @(posedge sys_clk);
        #1;
        chk("rst seg_n",    64'(seg_n),    64'(ALL_OFF));
        chk("rst new_flag", 64'(new_flag), 64'(0));
        chk("rst page_idx", 64'(page_idx), 64'(0));
        rst = 1'b0;
        step(1'b0, '0, 1'b0, 1'b0, 1'b0, "release");
        chk("release zeros", 64'(seg_n), 64'(ALL_40));

        // Capture and blink burst length.
        hi = 0;
        step(1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, "cap");
        if (new_flag) hi++;
        for (int k = 0; k < 20; k++) begin
            step(1'b0, '0, 1'b0, 1'b0, 1'b0, "burst");
            if (new_flag) hi++;
        end
        chk("burst length", 64'(hi), 64'(BH * BHV));
        chk("adbeef digits", 64'(seg_n), 64'(ADBEEF));

        // Paging and wrap.
        step(1'b0, '0, 1'b0, 1'b0, 1'b1, "page1");
        idle(1, "page1 show");
        chk("page1 digits", 64'(seg_n), 64'(PAGE1));
        chk("page1 idx",    64'(page_idx), 64'(1));
        step(1'b0, '0, 1'b0, 1'b0, 1'b1, "wrap");
        chk("wrap idx", 64'(page_idx), 64'(0));
        idle(1, "wrap show");

        // Capture wins over page_adv; hold blocks capture.
        step(1'b0, '0, 1'b0, 1'b0, 1'b1, "page1b");
        step(1'b1, 32'h1, 1'b0, 1'b0, 1'b1, "cap+adv");
        chk("cap+adv idx", 64'(page_idx), 64'(0));
        idle(1, "val1 show");
        chk("val1 digits", 64'(seg_n), 64'(VAL_1));
        idle(20, "val1 burst");
        step(1'b1, 32'h55, 1'b1, 1'b0, 1'b0, "hold");
        idle(3, "hold after");
        chk("hold digits", 64'(seg_n), 64'(VAL_1));
        chk("hold flag",   64'(new_flag), 64'(0));

        // Clear beats capture mid-burst.
        step(1'b1, 32'h1234, 1'b0, 1'b0, 1'b0, "cap1234");
        idle(6, "mid burst");
        step(1'b1, 32'hFFFF, 1'b0, 1'b1, 1'b0, "clear+cap");
        chk("clear flag", 64'(new_flag), 64'(0));
        idle(1, "clear show");
        chk("clear digits", 64'(seg_n), 64'(ALL_40));

        // Leading-zero cases.
        step(1'b1, 32'hA5, 1'b0, 1'b0, 1'b0, "capA5");
        idle(1, "A5 show");
        chk("A5 digits", 64'(seg_n), 64'(VAL_A5));
        idle(20, "A5 burst");
        step(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, "cap0");
        idle(1, "zero show");
        chk("zero digits", 64'(seg_n), 64'(VAL_0));

        // Asynchronous reset in the middle of a burst.
        step(1'b1, 32'hCAFE, 1'b0, 1'b0, 1'b0, "capCAFE");
        idle(3, "pre reset");
        #2;
        rst = 1'b1;
        #1;
        chk("async rst seg_n",    64'(seg_n),    64'(ALL_OFF));
        chk("async rst new_flag", 64'(new_flag), 64'(0));
        chk("async rst page_idx", 64'(page_idx), 64'(0));
        m_val = '0; m_page = 0; m_on = 1'b0; m_cnt = 0;
        @(posedge sys_clk);
        #1;
        rst = 1'b0;
        idle(2, "post reset");
        chk("post reset digits", 64'(seg_n), 64'(ALL_40));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
